// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit pair per clock.
//
// Each RUN cycle the low bits of the operand shift registers pass through a
// full adder built from two half-adder stages plus an OR. A carry flip-flop
// links successive bits. The result is published in parallel with a one-cycle
// done pulse.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-high reset
//   start    - request; accepted only in IDLE or DONE
//   a, b     - operands, captured on the accepting edge only
//   cin      - carry-in, captured on the accepting edge only
//   busy     - high while an addition is in progress
//   done     - single-cycle pulse, sum/cout valid
//   sum      - registered result, held until the next completion
//   cout     - registered carry-out of the last completed addition
//   overflow - (only with SERIAL_ADDER_OVF_EN) two's-complement signed overflow
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the overflow output.

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Full-adder cell: two half adders and an OR.
    logic ha1_p, ha1_g, ha2_s, ha2_t, carry_nxt;

    assign ha1_p     = a_sh_q[0] ^ b_sh_q[0];
    assign ha1_g     = a_sh_q[0] & b_sh_q[0];
    assign ha2_s     = ha1_p ^ carry_q;
    assign ha2_t     = ha1_p & carry_q;
    assign carry_nxt = ha1_g | ha2_t;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    acc_d   = '0;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = {ha2_s, acc_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    sum_d   = {ha2_s, acc_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    // On the final bit carry_q is the carry into the MSB.
                    ovf_d   = carry_q ^ carry_nxt;
`endif
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a scoreboard queue.
// Define SERIAL_ADDER_OVF_EN for both files to also check overflow.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic       overflow;
`endif

    serial_adder #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .overflow(overflow),
`endif
        .cout    (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // Monitor: pops on every done pulse, checks sum/cout hold otherwise.
    logic [7:0] held_sum = '0;
    logic       held_cout = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            held_sum  = '0;
            held_cout = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL extra_done: got done with sum 0x%0h, required no done", sum);
            end else begin
                e = sb.pop_front();
                check("sum", {24'd0, sum}, {24'd0, e.s});
                check("cout", {31'd0, cout}, {31'd0, e.c});
`ifdef SERIAL_ADDER_OVF_EN
                check("overflow", {31'd0, overflow}, {31'd0, e.o});
`endif
            end
            held_sum  = sum;
            held_cout = cout;
        end else begin
            check("sum_stable", {24'd0, sum}, {24'd0, held_sum});
            check("cout_stable", {31'd0, cout}, {31'd0, held_cout});
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input bit push, input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a = ia;
        b = ib;
        cin = ic;
        if (push) begin
            e.s = es;
            e.c = ec;
            e.o = eo;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < maxc);
        if (!done) begin
            total++;
            $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, maxc);
        end
    endtask

    initial begin
        int busy_cnt, cyc, npulse, last, gap_bad;

        #12 reset = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, overflow}, 32'd0);
`endif

        // 1: 0+0, latency and busy window
        issue(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        busy_cnt = 0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (busy) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, 8);
        check("done_latency", cyc, 9);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_single", {31'd0, done}, 32'd0);

        // 2: carry out, then carry-in
        issue(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        wait_done("t2a", 20);
        issue(8'h5A, 8'h25, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1);
        wait_done("t2b", 20);

        // 3: start held high, three back-to-back operations
        repeat (3) begin
            exp_t e;
            e.s = 8'hFF;
            e.c = 1'b0;
            e.o = 1'b0;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        a = 8'h0F;
        b = 8'hF0;
        cin = 1'b0;
        npulse = 0;
        last = 0;
        gap_bad = 0;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (n == 19) start = 1'b0;
            if (done) begin
                if (npulse > 0 && n - last != 9) gap_bad++;
                if (npulse == 0 && n != 9) gap_bad++;
                npulse++;
                last = n;
            end
        end
        check("b2b_pulses", npulse, 3);
        check("b2b_spacing_errs", gap_bad, 0);

        // 4: start and operand changes during RUN are ignored
        issue(8'h3C, 8'h42, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t4", 20);
        repeat (15) @(negedge clk);
        check("t4_idle_busy", {31'd0, busy}, 32'd0);

        // 5: asynchronous reset mid-operation
        issue(8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_done", {31'd0, done}, 32'd0);
        check("ar_sum", {24'd0, sum}, 32'd0);
        check("ar_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("ar_ovf", {31'd0, overflow}, 32'd0);
`endif
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        issue(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
        wait_done("t5", 20);

`ifdef SERIAL_ADDER_OVF_EN
        // 6: signed overflow
        issue(8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
        wait_done("t6a", 20);
        issue(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        wait_done("t6b", 20);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
